// File: rtl/npu_result_collector_if.sv
// NPU result stream plus PS-side read port of npu_result_collector.
// The collector takes the slave view; the NPU/PS side (or a bench) takes the master view.
interface npu_result_collector_if #(
  parameter int DATA_W = 16
);
  logic [DATA_W-1:0] in_data;
  logic              in_vld;
  logic              rd_req;
  logic [DATA_W-1:0] rd_data;
  logic              rd_vld;

  modport master (output in_data, in_vld, rd_req, input  rd_data, rd_vld);
  modport slave  (input  in_data, in_vld, rd_req, output rd_data, rd_vld);
endinterface

// File: rtl/npu_result_collector.sv
// Receive-side sink for NPU inference results: FIFO buffer, per-run count, error flags.
// Optional RESULT_CHECKSUM_EN adds a wrapping 16-bit sum of accepted words (chk_sum/chk_vld).
module npu_result_collector #(
  parameter int DATA_W      = 16,
  parameter int NUM_RESULTS = 43,
  parameter int DEPTH       = 64,
  parameter int TIMEOUT_CYC = 262144
) (
  input  logic                   sys_clk,
  input  logic                   rst,
  input  logic                   arm,
  npu_result_collector_if.slave  bus,
  output logic [$clog2(DEPTH):0] level,
  output logic [6:0]             rx_cnt,
  output logic                   busy,
  output logic                   done,
  output logic                   err_ovf,
  output logic                   err_stray,
  output logic                   err_tmo
`ifdef RESULT_CHECKSUM_EN
  ,
  output logic [15:0]            chk_sum,
  output logic                   chk_vld
`endif
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam int GW = $clog2(TIMEOUT_CYC) + 1;

  typedef enum logic [1:0] {S_IDLE, S_COLLECT, S_DONE, S_TMO} state_e;

  state_e            state_q;
  logic              busy_q, done_q;
  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]     level_q, level_d;
  logic [6:0]        rx_cnt_q, rx_cnt_d;
  logic [GW-1:0]     gap_q, gap_d;
  logic              err_ovf_q, err_ovf_d;
  logic              err_stray_q, err_stray_d;
  logic              err_tmo_q, err_tmo_d;
  logic [DATA_W-1:0] rd_data_q;
  logic              rd_vld_q;

  logic in_coll, full, empty, pop, wr_try, push, last, tmo_fire;

  assign in_coll  = (state_q == S_COLLECT);
  assign full     = (level_q == LW'(DEPTH));
  assign empty    = (level_q == '0);
  assign pop      = bus.rd_req && !empty;
  // arm wins over a same-cycle word: the run restarts and that word is ignored
  assign wr_try   = in_coll && bus.in_vld && !arm;
  assign push     = wr_try && (!full || pop);
  assign last     = push && (rx_cnt_q == 7'(NUM_RESULTS - 1));
  assign tmo_fire = in_coll && !arm && !bus.in_vld && (gap_q == GW'(TIMEOUT_CYC - 1));

  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    level_d     = level_q;
    rx_cnt_d    = rx_cnt_q;
    gap_d       = gap_q;
    err_ovf_d   = err_ovf_q;
    err_stray_d = err_stray_q;
    err_tmo_d   = err_tmo_q;
    if (arm) begin
      wr_ptr_d    = '0;
      rd_ptr_d    = '0;
      level_d     = '0;
      rx_cnt_d    = '0;
      gap_d       = '0;
      err_ovf_d   = 1'b0;
      err_stray_d = 1'b0;
      err_tmo_d   = 1'b0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      level_d = level_q + LW'(push) - LW'(pop);
      if (push && rx_cnt_q != 7'(NUM_RESULTS)) rx_cnt_d = rx_cnt_q + 7'd1;
      if (in_coll) begin
        if (bus.in_vld)                       gap_d = '0;
        else if (gap_q != GW'(TIMEOUT_CYC-1)) gap_d = gap_q + GW'(1);
      end
      if (wr_try && full && !pop)   err_ovf_d   = 1'b1;
      if (bus.in_vld && !in_coll)   err_stray_d = 1'b1;
      if (tmo_fire)                 err_tmo_d   = 1'b1;
    end
  end

  always_ff @(posedge sys_clk) begin
    if (rst) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      level_q     <= '0;
      rx_cnt_q    <= '0;
      gap_q       <= '0;
      err_ovf_q   <= 1'b0;
      err_stray_q <= 1'b0;
      err_tmo_q   <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      level_q     <= level_d;
      rx_cnt_q    <= rx_cnt_d;
      gap_q       <= gap_d;
      err_ovf_q   <= err_ovf_d;
      err_stray_q <= err_stray_d;
      err_tmo_q   <= err_tmo_d;
    end
  end

  // Storage is not reset; the pointers alone define what is valid.
  always_ff @(posedge sys_clk) begin
    if (push) mem[wr_ptr_q] <= bus.in_data;
  end

  // On a full-FIFO push+pop both pointers alias; the read sees the old head.
  always_ff @(posedge sys_clk) begin
    if (rst) begin
      rd_data_q <= '0;
      rd_vld_q  <= 1'b0;
    end else begin
      rd_vld_q <= pop;
      if (pop) rd_data_q <= mem[rd_ptr_q];
    end
  end

  always_ff @(posedge sys_clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else if (arm) begin
      state_q <= S_COLLECT;
      busy_q  <= 1'b1;
      done_q  <= 1'b0;
    end else begin
      case (state_q)
        S_COLLECT: begin
          if (last) begin
            state_q <= S_DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end else if (tmo_fire) begin
            state_q <= S_TMO;
            busy_q  <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef RESULT_CHECKSUM_EN
  logic [15:0] chk_sum_q;

  always_ff @(posedge sys_clk) begin
    if (rst || arm)  chk_sum_q <= '0;
    else if (push)   chk_sum_q <= chk_sum_q + 16'(bus.in_data);
  end

  assign chk_sum = chk_sum_q;
  assign chk_vld = done_q;
`endif

  assign bus.rd_data = rd_data_q;
  assign bus.rd_vld  = rd_vld_q;
  assign level       = level_q;
  assign rx_cnt      = rx_cnt_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign err_ovf     = err_ovf_q;
  assign err_stray   = err_stray_q;
  assign err_tmo     = err_tmo_q;

endmodule

// File: tb/tb_npu_result_collector.sv
// Directed bench for npu_result_collector: main instance (DEPTH 64) plus a DEPTH 16 instance for overflow.
module tb_npu_result_collector;
  localparam int DW   = 16;
  localparam int NRES = 43;

  logic sys_clk = 1'b0;
  logic rst     = 1'b1;
  logic arm     = 1'b0;
  always #5 sys_clk = ~sys_clk;

  npu_result_collector_if #(.DATA_W(DW)) ifa();
  npu_result_collector_if #(.DATA_W(DW)) ifb();
  assign ifb.in_data = ifa.in_data;
  assign ifb.in_vld  = ifa.in_vld;
  assign ifb.rd_req  = ifa.rd_req;

  logic [6:0] a_level, a_rx;
  logic       a_busy, a_done, a_ovf, a_stray, a_tmo;
  logic [4:0] b_level;
  logic [6:0] b_rx;
  logic       b_busy, b_done, b_ovf, b_stray, b_tmo;
`ifdef RESULT_CHECKSUM_EN
  logic [15:0] a_sum, b_sum;
  logic        a_cv, b_cv;
`endif

  npu_result_collector #(.DATA_W(DW), .NUM_RESULTS(NRES), .DEPTH(64), .TIMEOUT_CYC(100)) dut (
    .sys_clk(sys_clk), .rst(rst), .arm(arm), .bus(ifa.slave),
    .level(a_level), .rx_cnt(a_rx), .busy(a_busy), .done(a_done),
    .err_ovf(a_ovf), .err_stray(a_stray), .err_tmo(a_tmo)
`ifdef RESULT_CHECKSUM_EN
    , .chk_sum(a_sum), .chk_vld(a_cv)
`endif
  );

  npu_result_collector #(.DATA_W(DW), .NUM_RESULTS(NRES), .DEPTH(16), .TIMEOUT_CYC(100)) dut_s (
    .sys_clk(sys_clk), .rst(rst), .arm(arm), .bus(ifb.slave),
    .level(b_level), .rx_cnt(b_rx), .busy(b_busy), .done(b_done),
    .err_ovf(b_ovf), .err_stray(b_stray), .err_tmo(b_tmo)
`ifdef RESULT_CHECKSUM_EN
    , .chk_sum(b_sum), .chk_vld(b_cv)
`endif
  );

  int pass_cnt = 0;
  int tot_cnt  = 0;
  int fail_cnt = 0;

  logic [15:0] sbq[$];
  int          m_level = 0;
  int          m_rx    = 0;
  bit          m_coll  = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tot_cnt++;
    assert (obs === exp) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One cycle: drive, update the scoreboard, clock, then check the read port.
  task automatic drive(input bit a, input bit v, input logic [15:0] d, input bit r);
    bit          pop;
    logic [15:0] want;
    arm = a; ifa.in_vld = v; ifa.in_data = d; ifa.rd_req = r;
    pop  = !rst && r && (m_level > 0);
    want = '0;
    if (pop) begin
      want = sbq.pop_front();
      m_level--;
    end
    if (rst || a) begin
      sbq.delete();
      m_level = 0;
      m_rx    = 0;
      m_coll  = a && !rst;
    end else if (v && m_coll) begin
      sbq.push_back(d);
      m_level++;
      m_rx++;
      if (m_rx == NRES) m_coll = 1'b0;
    end
    @(posedge sys_clk);
    #1;
    arm = 1'b0; ifa.in_vld = 1'b0; ifa.rd_req = 1'b0;
    chk("rd_vld", {31'b0, ifa.rd_vld}, {31'b0, pop});
    if (pop) chk("rd_data", {16'b0, ifa.rd_data}, {16'b0, want});
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 16'h0, 1'b0);
  endtask

  initial begin
    ifa.in_vld = 1'b0; ifa.in_data = '0; ifa.rd_req = 1'b0;
    idle(2);
    chk("rst_level", a_level, 0);
    chk("rst_rx", a_rx, 0);
    chk("rst_flags", {a_busy, a_done, a_ovf, a_stray, a_tmo}, 0);
    chk("rst_rd_data", ifa.rd_data, 0);
    rst = 1'b0;

    // full run of 43 words, then drain
    drive(1'b1, 1'b0, 16'h0, 1'b0);
    chk("arm_busy", a_busy, 1);
    for (int i = 0; i < NRES; i++) begin
      drive(1'b0, 1'b1, 16'h700F, 1'b0);
      if (i < NRES - 1) idle(9);
    end
    chk("t1_done", a_done, 1);
    chk("t1_busy", a_busy, 0);
    chk("t1_level", a_level, 43);
    chk("t1_rx", a_rx, 43);
    chk("t1_errs", {a_ovf, a_stray, a_tmo}, 0);
    for (int i = 0; i < NRES; i++) drive(1'b0, 1'b0, 16'h0, 1'b1);
    chk("t1_drained", a_level, 0);
    drive(1'b0, 1'b0, 16'h0, 1'b1);
    chk("t1_rd_hold", ifa.rd_data, 16'h700F);

    // overflow on the 16-deep instance
    drive(1'b1, 1'b0, 16'h0, 1'b0);
    for (int i = 0; i < 17; i++) begin
      drive(1'b0, 1'b1, 16'h0200 + 16'(i), 1'b0);
      if (i == 15) begin
        chk("t2_full_level", b_level, 16);
        chk("t2_no_ovf_yet", b_ovf, 0);
      end
    end
    chk("t2_level", b_level, 16);
    chk("t2_rx", b_rx, 16);
    chk("t2_ovf", b_ovf, 1);
    chk("t2_main_ovf", a_ovf, 0);

    // timeout after 100 idle cycles
    drive(1'b1, 1'b0, 16'h0, 1'b0);
    for (int i = 0; i < 5; i++) drive(1'b0, 1'b1, 16'h0100 + 16'(i), 1'b0);
    idle(99);
    chk("t3_busy_pre", a_busy, 1);
    chk("t3_tmo_pre", a_tmo, 0);
    idle(1);
    chk("t3_busy", a_busy, 0);
    chk("t3_tmo", a_tmo, 1);
    chk("t3_level", a_level, 5);
    m_coll = 1'b0;
    for (int i = 0; i < 5; i++) drive(1'b0, 1'b0, 16'h0, 1'b1);
    chk("t3_drained", a_level, 0);

    // simultaneous push and pop at level 1
    drive(1'b1, 1'b0, 16'h0, 1'b0);
    chk("t5_tmo_clr", a_tmo, 0);
    drive(1'b0, 1'b1, 16'hAAAA, 1'b0);
    drive(1'b0, 1'b1, 16'hBBBB, 1'b1);
    chk("t5_level", a_level, 1);
    chk("t5_rx", a_rx, 2);
    drive(1'b0, 1'b0, 16'h0, 1'b1);
    drive(1'b0, 1'b0, 16'h0, 1'b1);
    chk("t5_empty", a_level, 0);

    // reset mid-run
    drive(1'b1, 1'b0, 16'h0, 1'b0);
    for (int i = 0; i < 20; i++) drive(1'b0, 1'b1, 16'h2000 + 16'(i), 1'b0);
    chk("t6_level20", a_level, 20);
    rst = 1'b1;
    drive(1'b0, 1'b0, 16'h0, 1'b1);
    rst = 1'b0;
    chk("t6_level", a_level, 0);
    chk("t6_rx", a_rx, 0);
    chk("t6_busy_done", {a_busy, a_done}, 0);
    chk("t6_rd_data", ifa.rd_data, 0);

    // stray word in IDLE
    drive(1'b0, 1'b1, 16'h1234, 1'b0);
    chk("t4_stray", a_stray, 1);
    chk("t4_level", a_level, 0);
    drive(1'b1, 1'b0, 16'h0, 1'b0);
    chk("t4_stray_clr", a_stray, 0);
    chk("t4_busy", a_busy, 1);

`ifdef RESULT_CHECKSUM_EN
    chk("cs_clr", a_sum, 0);
    drive(1'b0, 1'b1, 16'h0001, 1'b0);
    drive(1'b0, 1'b1, 16'h0002, 1'b0);
    drive(1'b0, 1'b1, 16'hFFFF, 1'b0);
    chk("cs_sum", a_sum, 16'h0002);
    chk("cs_vld", a_cv, 0);
`endif

    $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
    $finish;
  end
endmodule

// File: doc/npu_result_collector.md
Name: npu_result_collector

Overview:
- Receive-side sink for the NPU inference result stream: captures each 16-bit result word (two 8-bit numbers) presented with a 1-cycle valid pulse.
- Buffers the words in a FIFO and tracks the expected result count per inference run.
- Flags completion, overflow, stray and timeout errors.
- Lets the PS-side controller drain the results through a request/valid read port. Sits between the NPU output port and the PS register/readback logic.

Parameters:
- DATA_W, 16, result word width.
- NUM_RESULTS, 43, words expected per run (1..DEPTH).
- DEPTH, 64, FIFO depth in words, power of two.
- TIMEOUT_CYC, 262144, max idle cycles between arm/last word and the next word before a timeout.

Ports:
- sys_clk  in  1  system clock.
- rst  in  1  synchronous active-high reset.
- arm  in  1  1-cycle pulse; starts a run (issued with the NPU's cal_start).
- in_data  in  DATA_W  result word from NPU.
- in_vld  in  1  1-cycle qualifier for in_data.
- rd_req  in  1  read request from PS side.
- rd_data  out  DATA_W  read word.
- rd_vld  out  1  1-cycle pulse, rd_data valid.
- level  out  $clog2(DEPTH)+1  words currently in FIFO.
- rx_cnt  out  7  words accepted this run.
- busy  out  1  high in COLLECT.
- done  out  1  high in DONE.
- err_ovf  out  1  sticky; word dropped because FIFO full.
- err_stray  out  1  sticky; in_vld outside COLLECT.
- err_tmo  out  1  sticky; timeout fired.

Behaviour:
- Interface: one clock, sys_clk. Reset rst is synchronous and active-high; it is sampled only on the sys_clk rising edge.
- Reset: state IDLE; FIFO empty; level=0, rx_cnt=0; rd_data=0; rd_vld=0, busy=0, done=0; all err_* = 0; gap counter = 0. Reset mid-run discards all buffered data.
- States: IDLE, COLLECT, DONE, TMO.
  - IDLE --arm--> COLLECT.
  - COLLECT --accepted word making rx_cnt==NUM_RESULTS--> DONE.
  - COLLECT --gap counter reaches TIMEOUT_CYC-1 with no in_vld--> TMO, err_tmo=1.
  - DONE/TMO --arm--> COLLECT.
  - arm in COLLECT restarts the run.
- On arm (any state): FIFO flushed, rx_cnt=0, gap=0, err_* cleared. If in_vld is high in the same cycle, that word is ignored.
- Write (COLLECT, in_vld=1):
  - If level<DEPTH or a read pops in the same cycle: push in_data, rx_cnt+1, gap=0.
  - If full with no pop: word dropped, err_ovf=1, rx_cnt unchanged, gap=0.
- Gap counter increments each COLLECT cycle without in_vld. It saturates and is not used outside COLLECT.
- in_vld in IDLE/DONE/TMO: word ignored, err_stray=1.
- Read:
  - rd_req with level>0 (any state): pop; rd_data = head word and rd_vld=1 on the next cycle (latency 1).
  - rd_req with level==0: no pop, rd_vld=0, rd_data holds its last value.
  - rd_vld is low on every cycle without a pop in the prior cycle.
- Simultaneous push+pop: both occur; level unchanged. Pop on empty plus push in the same cycle: push only.
- Pointers wrap modulo DEPTH. level ranges 0..DEPTH.
- rx_cnt saturates at NUM_RESULTS; the FSM leaves COLLECT at that point.

Optional Feature:
- Macro RESULT_CHECKSUM_EN.
- Defined:
  - Adds output chk_sum (16-bit): wrapping sum of every word accepted this run, cleared on arm/reset, updated the cycle after each accepted push.
  - Adds output chk_vld: high in DONE.
- Not defined: ports absent, no adder logic.

Test Plan:
1. arm, then 43 in_vld pulses of 16'h700F spaced 10 cycles -> done=1 one cycle after 43rd word; level=43; rx_cnt=43; no err_*. Then 43 rd_req -> 43 rd_vld pulses, each 16'h700F one cycle after request; level=0.
2. DEPTH=64, NUM_RESULTS=64, no reads, 65th in_vld after refilling via second arm without draining is not possible; instead NUM_RESULTS=43 run with DEPTH=16 -> 16 words stored, 17th sets err_ovf=1, level stays 16, rx_cnt=16.
3. arm, TIMEOUT_CYC=100, 5 words then silence -> TMO after 100 idle cycles, err_tmo=1, busy=0, level=5 still readable.
4. in_vld while IDLE -> err_stray=1, level=0. Then arm -> err_stray cleared.
5. level=1, rd_req and in_vld same cycle in COLLECT -> level stays 1; rd_data = old head; rx_cnt+1. rd_req at level=0 -> rd_vld stays 0.
6. rst asserted mid-run with level=20 -> next cycle: IDLE, level=0, done=0, rd_vld=0. With RESULT_CHECKSUM_EN: 3 words 16'h0001/16'h0002/16'hFFFF -> chk_sum=16'h0002.
